rv32m_seq_unit: RTL and testbench



---
 rtl/rv32m_seq_unit.sv | 202 ++++++++++++++++++++
 tb/tb_rv32m_seq_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_seq_unit.sv
// rv32m_seq_unit: iterative RV32M multiply/divide unit for the EX-stage START/READY handshake.
// Radix-2: 32 shift-add steps for multiply, 32 restoring shift-subtract steps for divide.
//
// Ports:
//   i_clk    clock, all state on rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  request valid (level); dropping it in CALC/FIX aborts the operation
//   i_m_cnt  funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   i_rs1    multiplicand / dividend
//   i_rs2    multiplier / divisor
//   o_out    result, valid while o_ready is high; holds between completions
//   o_ready  one-cycle completion pulse
//   o_busy   high while iterating or applying the sign fix
module rv32m_seq_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EARLY_OUT = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [2:0]       i_m_cnt,
    input  logic [WIDTH-1:0] i_rs1,
    input  logic [WIDTH-1:0] i_rs2,
    output logic [WIDTH-1:0] o_out,
    output logic             o_ready,
    output logic             o_busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] AllOne = {WIDTH{1'b1}};

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e            r_state;
    logic [CntW-1:0]   r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic              r_spec;
    logic [WIDTH-1:0]  r_spec_val;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic [WIDTH-1:0]  r_out;
    logic              r_ready;
    logic              r_busy;

    // Operand decode on the request inputs (used only at the capture edge)
    logic              w_is_div;
    logic              w_rs1_sgn;
    logic              w_rs2_sgn;
    logic [WIDTH-1:0]  w_rs1_mag;
    logic [WIDTH-1:0]  w_rs2_mag;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_spec;
    logic [WIDTH-1:0]  w_spec_val;
    logic              w_neg;

    assign w_is_div   = i_m_cnt[2];
    assign w_rs1_sgn  = (i_m_cnt == 3'b001) || (i_m_cnt == 3'b010) ||
                        (i_m_cnt == 3'b100) || (i_m_cnt == 3'b110);
    assign w_rs2_sgn  = (i_m_cnt == 3'b001) || (i_m_cnt == 3'b100) || (i_m_cnt == 3'b110);
    assign w_rs1_mag  = (w_rs1_sgn && i_rs1[WIDTH-1]) ? -i_rs1 : i_rs1;
    assign w_rs2_mag  = (w_rs2_sgn && i_rs2[WIDTH-1]) ? -i_rs2 : i_rs2;
    assign w_div_zero = w_is_div && (i_rs2 == '0);
    assign w_ovf      = w_is_div && !i_m_cnt[0] && (i_rs1 == MinNeg) && (i_rs2 == AllOne);
    assign w_spec     = w_div_zero || w_ovf;

    always_comb begin
        w_spec_val = '0;
        if (w_div_zero) begin
            w_spec_val = i_m_cnt[1] ? i_rs1 : AllOne;
        end else if (w_ovf) begin
            w_spec_val = i_m_cnt[1] ? '0 : MinNeg;
        end
    end

    always_comb begin
        w_neg = 1'b0;
        unique case (i_m_cnt)
            3'b001:         w_neg = i_rs1[WIDTH-1] ^ i_rs2[WIDTH-1];
            3'b010:         w_neg = i_rs1[WIDTH-1];
            3'b100:         w_neg = i_rs1[WIDTH-1] ^ i_rs2[WIDTH-1];
            3'b110:         w_neg = i_rs1[WIDTH-1];
            default:        w_neg = 1'b0;
        endcase
    end

    // Multiply step: {hi,lo} holds partial product above the remaining multiplier bits
    logic [WIDTH:0]    w_add;
    assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    // Divide step: hi is the partial remainder, lo shifts dividend out and quotient in
    logic [WIDTH:0]    w_sh;
    logic [WIDTH:0]    w_diff;
    logic              w_q_bit;
    assign w_sh    = {r_hi, r_lo[WIDTH-1]};
    assign w_diff  = w_sh - {1'b0, r_b};
    assign w_q_bit = !w_diff[WIDTH];

    // High word of the 64-bit negated product: borrow propagates only when lo is zero
    logic [WIDTH-1:0]  w_hi_neg;
    assign w_hi_neg = ~r_hi + {{(WIDTH-1){1'b0}}, (r_lo == '0)};

    logic [WIDTH-1:0]  w_fix;
    always_comb begin
        w_fix = '0;
        unique case (r_op)
            3'b000:                 w_fix = r_lo;
            3'b001, 3'b010, 3'b011: w_fix = r_neg ? w_hi_neg : r_hi;
            3'b100, 3'b101:         w_fix = r_neg ? -r_lo : r_lo;
            default:                w_fix = r_neg ? -r_hi : r_hi;
        endcase
        // Full-latency special cases: the iterated value is replaced, not sign-fixed
        if (r_spec) begin
            w_fix = r_spec_val;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_op       <= '0;
            r_neg      <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_val <= '0;
            r_b        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_out      <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_ready <= 1'b0;
                    if (i_start) begin
                        r_op       <= i_m_cnt;
                        r_neg      <= w_neg;
                        r_spec     <= w_spec;
                        r_spec_val <= w_spec_val;
                        r_cnt      <= '0;
                        r_hi       <= '0;
                        r_b        <= w_is_div ? w_rs2_mag : w_rs1_mag;
                        r_lo       <= w_is_div ? w_rs1_mag : w_rs2_mag;
                        if ((EARLY_OUT != 0) && w_spec) begin
                            r_out   <= w_spec_val;
                            r_ready <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (!i_start) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else if (r_cnt == CntW'(WIDTH)) begin
                        r_state <= StFix;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                        if (r_op[2]) begin
                            r_hi <= w_q_bit ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
                            r_lo <= {r_lo[WIDTH-2:0], w_q_bit};
                        end else begin
                            r_hi <= w_add[WIDTH:1];
                            r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
                        end
                    end
                end
                StFix: begin
                    r_busy <= 1'b0;
                    if (!i_start) begin
                        r_state <= StIdle;
                    end else begin
                        r_out   <= w_fix;
                        r_ready <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_ready <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_out   = r_out;
    assign o_ready = r_ready;
    assign o_busy  = r_busy;

endmodule

// File: tb/tb_rv32m_seq_unit.sv
module tb_rv32m_seq_unit;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        start_a, start_b;
    logic [2:0]  op_a, op_b;
    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;
    logic [31:0] out_a, out_b;
    logic        rdy_a, rdy_b, busy_a, busy_b;

    int          n_checks;
    int          n_fail;
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    vec_t        tab_a[$];
    vec_t        tab_b[$];
    logic [31:0] last_a;

    rv32m_seq_unit #(.WIDTH(32), .EARLY_OUT(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_m_cnt(op_a),
        .i_rs1(rs1_a), .i_rs2(rs2_a), .o_out(out_a), .o_ready(rdy_a), .o_busy(busy_a)
    );

    rv32m_seq_unit #(.WIDTH(32), .EARLY_OUT(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_m_cnt(op_b),
        .i_rs1(rs1_b), .i_rs2(rs2_b), .o_out(out_b), .o_ready(rdy_b), .o_busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboards: every READY pulse pops one expected result
    always @(posedge clk) begin
        #1;
        if (rdy_a) begin
            if (q_a.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready_a: got %h, expected no READY", out_a);
            end else begin
                check("out_a", out_a, q_a.pop_front());
            end
        end
        if (rdy_b) begin
            if (q_b.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ready_b: got %h, expected no READY", out_b);
            end else begin
                check("out_b", out_b, q_b.pop_front());
            end
        end
    end

    task automatic add(input bit sel, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
        if (sel) tab_b.push_back(v);
        else tab_a.push_back(v);
    endtask

    // Counts edges from the current sample point until READY is seen
    task automatic wait_ready(input bit sel, input int max, output int n);
        n = 0;
        while (!(sel ? rdy_b : rdy_a) && n < max) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(sel ? rdy_b : rdy_a)) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: got no READY after %0d cycles, expected READY", n);
        end
    endtask

    task automatic run_op(input bit sel, input vec_t v);
        int n;
        if (sel) q_b.push_back(v.exp);
        else q_a.push_back(v.exp);
        @(negedge clk);
        if (sel) begin
            op_b = v.op; rs1_b = v.a; rs2_b = v.b; start_b = 1'b1;
        end else begin
            op_a = v.op; rs1_a = v.a; rs2_a = v.b; start_a = 1'b1;
        end
        @(posedge clk);
        #1;
        check("busy_after_capture", {31'b0, sel ? busy_b : busy_a}, (v.lat != 0) ? 32'd1 : 32'd0);
        wait_ready(sel, 40, n);
        check("latency", n, v.lat);
        if (sel) start_b = 1'b0;
        else start_a = 1'b0;
        @(posedge clk);
        #1;
        check("ready_one_cycle", {31'b0, sel ? rdy_b : rdy_a}, 32'd0);
        if (!sel) last_a = v.exp;
    endtask

    initial begin
        int n;
        vec_t v;
        n_checks = 0;
        n_fail   = 0;
        last_a   = '0;
        rst_n = 1'b0;
        start_a = 1'b0; op_a = '0; rs1_a = '0; rs2_a = '0;
        start_b = 1'b0; op_b = '0; rs1_b = '0; rs2_b = '0;

        // Early-out unit
        add(0, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        add(0, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        add(0, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        add(0, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        add(0, 3'b001, 32'h80000000, 32'h7FFFFFFF, 32'hC0000000, 34);
        add(0, 3'b001, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 34);
        add(0, 3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
        add(0, 3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
        add(0, 3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34);
        add(0, 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        34);
        add(0, 3'b101, 32'd100,      32'd7,        32'd14,       34);
        add(0, 3'b111, 32'd100,      32'd7,        32'd2,        34);
        add(0, 3'b111, 32'hFFFFFFFF, 32'd10,       32'd5,        34);
        add(0, 3'b101, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34);
        add(0, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        add(0, 3'b110, 32'd5,        32'd0,        32'd5,        0);
        add(0, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        add(0, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
        add(0, 3'b100, 32'hFFFFFFEC, 32'd0,        32'hFFFFFFFF, 0);
        // Full-latency unit: specials come out of the iterative path
        add(1, 3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 34);
        add(1, 3'b110, 32'd5,        32'd0,        32'd5,        34);
        add(1, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34);
        add(1, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        34);
        add(1, 3'b100, 32'hFFFFFFEC, 32'd0,        32'hFFFFFFFF, 34);
        add(1, 3'b110, 32'hFFFFFFEC, 32'd0,        32'hFFFFFFEC, 34);
        add(1, 3'b111, 32'd9,        32'd0,        32'd9,        34);

        #12;
        check("reset_out", out_a, 32'd0);
        check("reset_ready", {31'b0, rdy_a}, 32'd0);
        check("reset_busy", {31'b0, busy_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tab_a.size(); i++) run_op(0, tab_a[i]);

        // Abort 10 cycles after capture: no READY, OUT unchanged
        @(negedge clk);
        op_a = 3'b000; rs1_a = 32'h1234; rs2_a = 32'd5; start_a = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'b0, busy_a}, 32'd0);
        check("abort_out_held", out_a, last_a);
        repeat (40) @(posedge clk);
        #1;
        check("abort_out_still", out_a, last_a);
        v.op = 3'b000; v.a = 32'd3; v.b = 32'd4; v.exp = 32'd12; v.lat = 34;
        run_op(0, v);

        // Back-to-back: START held, operands change in the READY cycle
        q_a.push_back(32'd391);
        q_a.push_back(32'd6);
        @(negedge clk);
        op_a = 3'b000; rs1_a = 32'd17; rs2_a = 32'd23; start_a = 1'b1;
        @(posedge clk);
        #1;
        wait_ready(0, 40, n);
        check("b2b_first_latency", n, 34);
        op_a = 3'b101; rs1_a = 32'd20; rs2_a = 32'd3;
        @(posedge clk);
        #1;
        wait_ready(0, 45, n);
        check("b2b_gap", n + 1, 36);
        start_a = 1'b0;
        @(posedge clk);
        #1;
        check("b2b_ready_drop", {31'b0, rdy_a}, 32'd0);

        for (int i = 0; i < tab_b.size(); i++) run_op(1, tab_b[i]);

        // Reset mid-CALC: outputs clear at once, no READY follows
        @(negedge clk);
        op_a = 3'b000; rs1_a = 32'd9; rs2_a = 32'd9; start_a = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", out_a, 32'd0);
        check("rst_mid_ready", {31'b0, rdy_a}, 32'd0);
        check("rst_mid_busy", {31'b0, busy_a}, 32'd0);
        start_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;

        check("scoreboard_a_empty", q_a.size(), 32'd0);
        check("scoreboard_b_empty", q_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
